// File: rtl/request_encoder4x2.sv
// request_encoder4x2
//   Captures one-cycle request pulses into a pending register and hands them
//   out one at a time as a 2-bit code with a valid/ack handshake. Requests are
//   granted in round-robin order, starting after the most recently granted
//   index. A request that arrives while the same bit is still pending, and is
//   not being granted on that edge, merges with the pending one. The lost
//   event sets a sticky overflow flag.
//
// Ports
//   clk     : clock; all state updates on its rising edge
//   rst     : synchronous active-high reset
//   en      : enables request capture and new grants
//   in      : request pulses, in[i] requests code i
//   ack     : consumer accepts dout while valid=1
//   dout    : encoded index of the granted request
//   valid   : dout holds a grant that has not been accepted yet
//   pending : registered requests that have not been granted yet
//   ovf     : sticky flag, set when a request event is lost
module request_encoder4x2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] in,
  input  logic       ack,
  output logic [1:0] dout,
  output logic       valid,
  output logic [3:0] pending,
  output logic       ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_r, state_next_s;
  logic [1:0] dout_r, dout_next_s;
  logic [3:0] pending_r, pending_next_s;
  logic       ovf_r, ovf_next_s;
  logic [1:0] ptr_r, ptr_next_s;

  logic       grant_s;
  logic [1:0] grant_idx_s;
  logic       grant_found_s;
  logic [3:0] grant_mask_s;
  logic [3:0] capture_s;

  // Round-robin pick: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4) and return
  // {found, index} of the first set bit.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      // Scanning from the far end lets the nearest hit overwrite farther ones.
      idx = ptr + 2'(k);
      if (req[idx]) begin
        result = {1'b1, idx};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Grant selection, pending/overflow update and next-state logic.
  always_comb begin
    state_next_s   = state_r;
    dout_next_s    = dout_r;
    ptr_next_s     = ptr_r;
    grant_s        = 1'b0;
    grant_mask_s   = 4'b0000;
    {grant_found_s, grant_idx_s} = rr_pick(pending_r, ptr_r);

    // A grant is allowed in IDLE, or in HOLD on the edge the current one is accepted.
    case (state_r)
      IDLE: begin
        grant_s = en && grant_found_s;
        if (grant_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD: begin
        if (ack) begin
          grant_s = en && grant_found_s;
          if (grant_s) begin
            state_next_s = HOLD;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          grant_s      = 1'b0;
          state_next_s = HOLD;
        end
      end
      default: begin
        grant_s      = 1'b0;
        state_next_s = IDLE;
      end
    endcase

    if (grant_s) begin
      dout_next_s  = grant_idx_s;
      ptr_next_s   = grant_idx_s + 2'd1;
      grant_mask_s = 4'b0001 << grant_idx_s;
    end else begin
      dout_next_s  = dout_r;
      ptr_next_s   = ptr_r;
      grant_mask_s = 4'b0000;
    end

    if (en) begin
      capture_s = in;
    end else begin
      capture_s = 4'b0000;
    end

    // A bit granted on this edge may be re-requested without loss.
    pending_next_s = (pending_r & ~grant_mask_s) | capture_s;
    ovf_next_s     = ovf_r | (|(capture_s & pending_r & ~grant_mask_s));
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      dout_r    <= 2'b00;
      pending_r <= 4'b0000;
      ovf_r     <= 1'b0;
      ptr_r     <= 2'b00;
    end else begin
      state_r   <= state_next_s;
      dout_r    <= dout_next_s;
      pending_r <= pending_next_s;
      ovf_r     <= ovf_next_s;
      ptr_r     <= ptr_next_s;
    end
  end

  assign dout    = dout_r;
  assign valid   = (state_r == HOLD);
  assign pending = pending_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_request_encoder4x2.sv
// Directed testbench for request_encoder4x2. Each scenario task drives inputs
// just after a rising edge and compares {valid, dout, pending, ovf} one time
// unit after the following edge.
module tb_request_encoder4x2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] in;
  logic       ack;
  logic [1:0] dout;
  logic       valid;
  logic [3:0] pending;
  logic       ovf;

  int n_checks;
  int n_fail;

  request_encoder4x2 dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (in),
    .ack     (ack),
    .dout    (dout),
    .valid   (valid),
    .pending (pending),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected word layout: {valid, dout[1:0], pending[3:0], ovf}
  task automatic expect_state(input string name, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {valid, dout, pending, ovf};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid=%b dout=%0d pending=%b ovf=%b, expected valid=%b dout=%0d pending=%b ovf=%b",
               name, obs[7], obs[6:5], obs[4:1], obs[0], exp[7], exp[6:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; in = 4'b0000; ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Reset must win over active en/in/ack.
    rst = 1'b1; en = 1'b1; in = 4'b1111; ack = 1'b1;
    tick();
    expect_state("reset_first_edge", {1'b0, 2'd0, 4'b0000, 1'b0});
    tick();
    expect_state("reset_held", {1'b0, 2'd0, 4'b0000, 1'b0});
    rst = 1'b0; en = 1'b0; in = 4'b0000; ack = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; in = 4'b0100; ack = 1'b1;
    tick();
    expect_state("single_capture", {1'b0, 2'd0, 4'b0100, 1'b0});
    in = 4'b0000;
    tick();
    expect_state("single_grant", {1'b1, 2'd2, 4'b0000, 1'b0});
    tick();
    expect_state("single_done", {1'b0, 2'd2, 4'b0000, 1'b0});
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_code [4];
    logic [3:0] exp_pend [4];
    exp_code = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_pend = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    do_reset();
    en = 1'b1; in = 4'b1111; ack = 1'b1;
    tick();
    expect_state("rr_capture", {1'b0, 2'd0, 4'b1111, 1'b0});
    in = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_state($sformatf("rr_grant%0d", i), {1'b1, exp_code[i], exp_pend[i], 1'b0});
    end
    tick();
    expect_state("rr_drain", {1'b0, 2'd3, 4'b0000, 1'b0});
  endtask

  task automatic test_hold_stall();
    do_reset();
    en = 1'b1; in = 4'b0010; ack = 1'b0;
    tick();
    in = 4'b0000;
    tick();
    expect_state("stall_grant", {1'b1, 2'd1, 4'b0000, 1'b0});
    in = 4'b1000;
    tick();
    expect_state("stall_capture", {1'b1, 2'd1, 4'b1000, 1'b0});
    in = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_state($sformatf("stall_hold%0d", i), {1'b1, 2'd1, 4'b1000, 1'b0});
    end
    ack = 1'b1;
    tick();
    expect_state("stall_next", {1'b1, 2'd3, 4'b0000, 1'b0});
    tick();
    expect_state("stall_idle", {1'b0, 2'd3, 4'b0000, 1'b0});
  endtask

  task automatic test_overflow();
    do_reset();
    en = 1'b1; in = 4'b0001; ack = 1'b0;
    tick();
    in = 4'b0000;
    tick();
    expect_state("ovf_hold0", {1'b1, 2'd0, 4'b0000, 1'b0});
    in = 4'b0010;
    tick();
    expect_state("ovf_first", {1'b1, 2'd0, 4'b0010, 1'b0});
    tick();
    expect_state("ovf_set", {1'b1, 2'd0, 4'b0010, 1'b1});
    in = 4'b0000;
    tick();
    expect_state("ovf_sticky", {1'b1, 2'd0, 4'b0010, 1'b1});
    ack = 1'b1;
    tick();
    expect_state("ovf_grant1", {1'b1, 2'd1, 4'b0000, 1'b1});
    tick();
    expect_state("ovf_single", {1'b0, 2'd1, 4'b0000, 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_state("ovf_cleared", {1'b0, 2'd0, 4'b0000, 1'b0});
  endtask

  task automatic test_same_bit_retain();
    do_reset();
    en = 1'b1; in = 4'b0001; ack = 1'b1;
    tick();
    tick();
    expect_state("retain_grant", {1'b1, 2'd0, 4'b0001, 1'b0});
    in = 4'b0000;
    tick();
    expect_state("retain_regrant", {1'b1, 2'd0, 4'b0000, 1'b0});
    tick();
    expect_state("retain_idle", {1'b0, 2'd0, 4'b0000, 1'b0});
  endtask

  task automatic test_disable();
    do_reset();
    en = 1'b1; in = 4'b0011; ack = 1'b0;
    tick();
    in = 4'b0000;
    tick();
    expect_state("dis_grant0", {1'b1, 2'd0, 4'b0010, 1'b0});
    en = 1'b0; in = 4'b1000; ack = 1'b1;
    tick();
    expect_state("dis_complete", {1'b0, 2'd0, 4'b0010, 1'b0});
    in = 4'b0000;
    tick();
    expect_state("dis_no_grant", {1'b0, 2'd0, 4'b0010, 1'b0});
    en = 1'b1;
    tick();
    expect_state("dis_reenable", {1'b1, 2'd1, 4'b0000, 1'b0});
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    en = 1'b1; in = 4'b1000; ack = 1'b0;
    tick();
    in = 4'b0110;
    tick();
    in = 4'b0000;
    expect_state("mid_hold_setup", {1'b1, 2'd3, 4'b0110, 1'b0});
    rst = 1'b1; en = 1'b1; in = 4'b1111; ack = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; in = 4'b0000; ack = 1'b0;
    expect_state("mid_hold_reset", {1'b0, 2'd0, 4'b0000, 1'b0});
    // Leave ptr at 2 by granting code 1, then reset: search must restart at 0.
    en = 1'b1; in = 4'b0010; ack = 1'b1;
    tick();
    in = 4'b0000;
    tick();
    expect_state("ptr_pre_grant1", {1'b1, 2'd1, 4'b0000, 1'b0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in = 4'b0110;
    tick();
    in = 4'b0000;
    tick();
    expect_state("ptr_after_reset", {1'b1, 2'd1, 4'b0100, 1'b0});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; in = 4'b0000; ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_stall();
    test_overflow();
    test_same_bit_retain();
    test_disable();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/request_encoder4x2.md
REQUEST_ENCODER4X2 -- requirements
Module: request_encoder4x2

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: enables request capture and new grants.
REQ-005 SHALL have port in, input, 4 bits: one-cycle request pulses; in[i] requests code i.
REQ-006 SHALL have port ack, input, 1 bit: consumer accepts dout while valid=1.
REQ-007 SHALL have port dout, output, 2 bits: encoded index of the granted request.
REQ-008 SHALL have port valid, output, 1 bit: dout holds an unaccepted grant.
REQ-009 SHALL have port pending, output, 4 bits: registered, not-yet-granted requests.
REQ-010 SHALL have port ovf, output, 1 bit: sticky flag, set when a request is lost.

Function
REQ-011 SHALL implement a 2-state FSM: IDLE (valid=0) and HOLD (valid=1).
REQ-012 SHALL compute a grant from registered pending only; in never reaches dout in the same cycle.
REQ-013 SHALL select the grant round-robin: search order ptr, ptr+1, ptr+2, ptr+3 mod 4; first set pending bit wins.
REQ-014 SHALL set ptr to (granted index + 1) mod 4 on each grant, wrapping 3 -> 0.
REQ-015 SHALL grant in IDLE when en=1 and pending!=0: load dout, set valid=1, go to HOLD.
REQ-016 SHALL keep dout and valid stable in HOLD while ack=0, regardless of en or in.
REQ-017 SHALL complete the transfer in HOLD on ack=1; if en=1 and pending!=0, grant the next code in the same edge and stay in HOLD (back-to-back, no bubble); otherwise go to IDLE with valid=0.
REQ-018 SHALL ignore ack while in IDLE.
REQ-019 SHALL update pending as: next = (pending & ~grant_mask) | (en ? in : 0), where grant_mask is the one-hot of the index granted on this edge, or 0 if no grant.
REQ-020 SHALL retain a new in[i] that arrives on the same edge that bit i is granted; it becomes pending again and is not an overflow.
REQ-021 SHALL set ovf when en=1, in[i]=1, pending[i]=1 and bit i is not granted on that edge; the request merges and one event is lost.
REQ-022 SHALL clear ovf only by rst.
REQ-023 SHALL, when en=0, discard in, make no new grant, and still complete an outstanding HOLD on ack, returning to IDLE.
REQ-024 SHALL give an earliest latency of 2 edges from an in pulse to valid=1: capture at edge N, valid from edge N+1.

Reset
REQ-025 SHALL, on clk edge with rst=1, force state=IDLE, valid=0, dout=2'b00, pending=4'b0000, ovf=0, ptr=0.
REQ-026 SHALL give rst priority over en, in and ack, including in the middle of a HOLD, discarding the outstanding grant.
REQ-027 SHALL have outputs take their reset values from the first edge with rst=1 and hold them until the first edge with rst=0.

Verification
REQ-028 Single request: en=1, in=4'b0100 for 1 cycle, ack=1 -> pending=4'b0100 after edge 1; valid=1, dout=2 after edge 2; then valid=0, pending=0.
REQ-029 Round-robin: after reset, in=4'b1111 in 1 cycle, ack held 1 -> dout sequence 0,1,2,3 back-to-back with valid continuously 1 for 4 cycles, then valid=0.
REQ-030 Hold/stall: grant dout=1 with ack=0 for 5 cycles while in=4'b1000 arrives -> dout stays 1 and valid stays 1; pending=4'b1000; after ack, dout=3.
REQ-031 Overflow: in=4'b0010 on two consecutive cycles with ack=0 while code 0 is held -> ovf=1 and stays 1; only a single code 1 is later granted; rst clears ovf.
REQ-032 Same-bit retain: in=4'b0001 on the edge granting code 0 -> pending=4'b0001, ovf=0, and code 0 is granted again.
REQ-033 Reset mid-HOLD: valid=1, dout=3, pending=4'b0110, then rst=1 for 1 cycle -> valid=0, dout=0, pending=0, ovf=0; the next grant search starts at index 0.
